// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single data-memory port between the CPU MEM
// stage and a debug/DMA loader port. The arbiter is non-preemptive and breaks
// ties round-robin. Each transfer is granted in IDLE, occupies the memory for
// WAIT ACCESS cycles, and is then acknowledged with a one-cycle pulse in DONE.
module dm_port_arbiter #(
    parameter int AW   = 12,
    parameter int DW   = 32,
    parameter int WAIT = 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [3:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [3:0]    dma_be,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          dm_en,
    output logic          dm_we,
    output logic [3:0]    dm_be,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata,
    output logic          owner,
    output logic          busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // The counter reloads to WAIT-1 so that cnt == 0 marks the final ACCESS cycle.
    localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       last_grant;   // 0 = CPU, 1 = DMA; reset to DMA so the CPU wins the first tie
    logic       we_lat;
    logic       grant_valid;
    logic       grant_port;   // 0 = CPU, 1 = DMA
    logic       last_cycle;

    // Choose the winner for a grant in IDLE: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        grant_valid = cpu_req | dma_req;
        if (cpu_req && dma_req) begin
            grant_port = ~last_grant;
        end else begin
            grant_port = dma_req;
        end
    end

    assign last_cycle = (state == S_ACCESS) && (cnt == 4'd0);

    // Transfer sequencer: IDLE -> ACCESS (WAIT cycles) -> DONE -> IDLE.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            we_lat     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        state      <= S_ACCESS;
                        cnt        <= CNT_INIT;
                        owner      <= grant_port;
                        last_grant <= grant_port;
                        we_lat     <= grant_port ? dma_we : cpu_we;
                    end
                end
                S_ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Latch the winner's request fields at grant; the memory sees only these until the next grant.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            dm_be    <= 4'd0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else if (state == S_IDLE && grant_valid) begin
            dm_be    <= grant_port ? dma_be    : cpu_be;
            dm_addr  <= grant_port ? dma_addr  : cpu_addr;
            dm_wdata <= grant_port ? dma_wdata : cpu_wdata;
        end
    end

    // Capture read data into the winner's register at the end of the last ACCESS cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else if (last_cycle && !we_lat) begin
            if (owner) begin
                dma_rdata <= dm_rdata;
            end else begin
                cpu_rdata <= dm_rdata;
            end
        end
    end

    assign dm_en     = (state == S_ACCESS);
    assign dm_we     = last_cycle & we_lat;
    assign busy      = (state != S_IDLE);
    assign cpu_ack   = (state == S_DONE) & ~owner;
    assign dma_ack   = (state == S_DONE) & owner;
    // The stall is gated by reset so the pipeline is never frozen while the arbiter is held in reset.
    assign cpu_stall = Rst & cpu_req & ~cpu_ack;

endmodule
